// File: rtl/buffer_pkg.sv
// Shared definitions for the line-buffer controller: activation codes,
// controller state encoding and the unit-count helper.
package buffer_pkg;

  localparam logic [1:0] ACT_LIBRE     = 2'b00;
  localparam logic [1:0] ACT_ACTIVA    = 2'b01;
  localparam logic [1:0] ACT_NO_ACTIVA = 2'b10;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RESET_UNID = 3'd1;
  localparam logic [2:0] ST_CONFIG     = 3'd2;
  localparam logic [2:0] ST_PRIMING    = 3'd3;
  localparam logic [2:0] ST_STREAMING  = 3'd4;

  // Number of units needed to hold w words at prof words per unit.
  function automatic int ceil_div(input int w, input int prof);
    return (w + prof - 1) / prof;
  endfunction

endpackage

// File: rtl/buffer_controlador_if.sv
// Control bundle between the pixel source / unit array and the controller.
interface buffer_controlador_if #(
  parameter int N_UNIDADES = 4,
  parameter int ANCHO_W    = 6
);
  logic                      config_valida;
  logic [ANCHO_W-1:0]        ancho_imagen;
  logic                      pixel_valido;
  logic                      reset_unidades;
  logic [2*N_UNIDADES-1:0]   valor_activacion;
  logic [N_UNIDADES-1:0]     write_req;
  logic [N_UNIDADES-1:0]     read_req;
  logic                      config_lista;
  logic                      linea_lista;
  logic                      error_config;

  modport master (
    output config_valida, ancho_imagen, pixel_valido,
    input  reset_unidades, valor_activacion, write_req, read_req,
           config_lista, linea_lista, error_config
  );

  modport slave (
    input  config_valida, ancho_imagen, pixel_valido,
    output reset_unidades, valor_activacion, write_req, read_req,
           config_lista, linea_lista, error_config
  );
endinterface

// File: rtl/buffer_mapa_req.sv
// Combinational map from controller state and pixel count to per-unit
// write/read request masks.
module buffer_mapa_req
  import buffer_pkg::*;
#(
  parameter int N_UNIDADES  = 4,
  parameter int PROF_UNIDAD = 8,
  parameter int ANCHO_W     = 6,
  parameter int KW          = 3
) (
  input  logic [2:0]            state,
  input  logic [ANCHO_W-1:0]    c,
  input  logic [KW-1:0]         k,
  input  logic                  pixel_valido,
  output logic [N_UNIDADES-1:0] write_req,
  output logic [N_UNIDADES-1:0] read_req
);
  localparam int SH = $clog2(PROF_UNIDAD);

  logic [ANCHO_W-1:0] j;
  assign j = c >> SH;

  // While priming, the unit being filled is j; every unit before it is full
  // and passes one word forward per accepted pixel.
  always_comb begin
    write_req = '0;
    read_req  = '0;
    if (pixel_valido) begin
      case (state)
        ST_PRIMING: begin
          for (int i = 0; i < N_UNIDADES; i++) begin
            write_req[i] = (i <= int'(j));
            read_req[i]  = (i <  int'(j));
          end
        end
        ST_STREAMING: begin
          for (int i = 0; i < N_UNIDADES; i++) begin
            write_req[i] = (i < int'(k));
            read_req[i]  = (i < int'(k));
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/buffer_controlador.sv
// Sequences a chain of FIFO buffer units into one line buffer of the
// configured width: unit reset, activation, priming, then streaming.
module buffer_controlador
  import buffer_pkg::*;
#(
  parameter int N_UNIDADES  = 4,
  parameter int PROF_UNIDAD = 8,
  parameter int ANCHO_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  buffer_controlador_if.slave  bus
);
  localparam int KW   = $clog2(N_UNIDADES + 1);
  localparam int MAXW = N_UNIDADES * PROF_UNIDAD;

  logic [2:0]              state;
  logic [ANCHO_W-1:0]      c, w;
  logic [KW-1:0]           k;
  logic                    cfg_ok, pix;
  logic [2*N_UNIDADES-1:0] act_codes;

  assign cfg_ok = (bus.ancho_imagen != '0) && (int'(bus.ancho_imagen) <= MAXW);
  // A configuration request in the same cycle wins over the pixel.
  assign pix    = bus.pixel_valido && !bus.config_valida && !reset;

  for (genvar i = 0; i < N_UNIDADES; i++) begin : g_act
    assign act_codes[2*i +: 2] = (i < int'(k)) ? ACT_ACTIVA : ACT_NO_ACTIVA;
  end

  buffer_mapa_req #(
    .N_UNIDADES (N_UNIDADES),
    .PROF_UNIDAD(PROF_UNIDAD),
    .ANCHO_W    (ANCHO_W),
    .KW         (KW)
  ) u_mapa (
    .state       (state),
    .c           (c),
    .k           (k),
    .pixel_valido(pix),
    .write_req   (bus.write_req),
    .read_req    (bus.read_req)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= ST_IDLE;
      c                    <= '0;
      w                    <= '0;
      k                    <= '0;
      bus.reset_unidades   <= 1'b1;
      bus.valor_activacion <= '0;
      bus.config_lista     <= 1'b0;
      bus.linea_lista      <= 1'b0;
      bus.error_config     <= 1'b0;
    end else begin
      bus.reset_unidades <= 1'b0;
      if (bus.config_valida) begin
        bus.valor_activacion <= '0;
        bus.config_lista     <= 1'b0;
        bus.linea_lista      <= 1'b0;
        if (cfg_ok) begin
          w                  <= bus.ancho_imagen;
          k                  <= KW'(ceil_div(int'(bus.ancho_imagen), PROF_UNIDAD));
          c                  <= '0;
          bus.error_config   <= 1'b0;
          bus.reset_unidades <= 1'b1;
          state              <= ST_RESET_UNID;
        end else begin
          bus.error_config <= 1'b1;
          state            <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_RESET_UNID: begin
            c                    <= '0;
            bus.valor_activacion <= act_codes;
            state                <= ST_CONFIG;
          end
          ST_CONFIG: begin
            bus.config_lista <= 1'b1;
            state            <= ST_PRIMING;
          end
          ST_PRIMING: begin
            if (pix) begin
              c <= c + 1'b1;
              if (c + 1'b1 == w) begin
                bus.linea_lista <= 1'b1;
                state           <= ST_STREAMING;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_buffer_controlador.sv
// Randomized check of the line-buffer controller against a behavioural model
// plus a per-unit occupancy tracker.
module tb_buffer_controlador;
  import buffer_pkg::*;

  localparam int N  = 4;
  localparam int P  = 8;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  buffer_controlador_if #(.N_UNIDADES(N), .ANCHO_W(AW)) bus ();

  buffer_controlador #(.N_UNIDADES(N), .PROF_UNIDAD(P), .ANCHO_W(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 unit reset, 2 activation, 3 priming, 4 streaming
  int          m_ph, m_c, m_w, m_k;
  bit          m_err, m_ru, m_cl, m_ll;
  logic [7:0]  m_codes;
  int          occ [N];

  task automatic model_reset();
    m_ph = 0; m_c = 0; m_w = 0; m_k = 0;
    m_err = 0; m_ru = 1; m_cl = 0; m_ll = 0; m_codes = '0;
  endtask

  task automatic cyc(input bit r, input bit cv, input int aw, input bit pv);
    int wm, rm, cap, j;
    bit viol;
    reset             = r;
    bus.config_valida = cv;
    bus.ancho_imagen  = AW'(aw);
    bus.pixel_valido  = pv;
    #2;
    wm = 0; rm = 0;
    if (!r && !cv && pv) begin
      if (m_ph == 3) begin
        j  = m_c / P;
        wm = (1 << (j + 1)) - 1;
        rm = (1 << j) - 1;
      end else if (m_ph == 4) begin
        wm = (1 << m_k) - 1;
        rm = wm;
      end
    end
    chk("write_req",        64'(bus.write_req),        64'(wm));
    chk("read_req",         64'(bus.read_req),         64'(rm));
    chk("reset_unidades",   64'(bus.reset_unidades),   64'(m_ru));
    chk("valor_activacion", 64'(bus.valor_activacion), 64'(m_codes));
    chk("config_lista",     64'(bus.config_lista),     64'(m_cl));
    chk("linea_lista",      64'(bus.linea_lista),      64'(m_ll));
    chk("error_config",     64'(bus.error_config),     64'(m_err));
    // No unit may be read while empty or written while full (without a read).
    if (m_ru) for (int i = 0; i < N; i++) occ[i] = 0;
    for (int i = 0; i < N; i++) begin
      cap = (i < m_k - 1) ? P : (i == m_k - 1) ? m_w - (m_k - 1) * P : 0;
      if (bus.write_req[i] || bus.read_req[i]) begin
        viol = (bus.read_req[i] && occ[i] == 0) ||
               (bus.write_req[i] && !bus.read_req[i] && occ[i] >= cap);
        chk("occupancy", 64'(viol), 64'(0));
      end
      occ[i] += int'(bus.write_req[i]) - int'(bus.read_req[i]);
    end
    @(posedge clk);
    if (r) model_reset();
    else begin
      m_ru = 0;
      if (cv) begin
        m_codes = '0; m_cl = 0; m_ll = 0;
        if (aw != 0 && aw <= N * P) begin
          m_w = aw; m_k = (aw + P - 1) / P; m_c = 0;
          m_err = 0; m_ru = 1; m_ph = 1;
        end else begin
          m_err = 1; m_ph = 0;
        end
      end else if (m_ph == 1) begin
        for (int i = 0; i < N; i++) m_codes[2*i +: 2] = (i < m_k) ? 2'b01 : 2'b10;
        m_ph = 2;
      end else if (m_ph == 2) begin
        m_cl = 1; m_ph = 3;
      end else if (m_ph == 3 && pv) begin
        m_c++;
        if (m_c == m_w) begin m_ll = 1; m_ph = 4; end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 0, 1);
      if ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.config_valida = 1'b0;
    bus.ancho_imagen  = '0;
    bus.pixel_valido  = 1'b0;
    for (int i = 0; i < N; i++) occ[i] = 0;
    @(posedge clk); #1;
    model_reset();
    cyc(1, 0, 0, 1);
    idle(2);
    // Width 20: three active units, last holds 4 words
    cyc(0, 1, 20, 0);
    cyc(0, 0, 0, 1);
    idle(1);
    pixels(20);
    pixels(3);
    idle(1);
    // Rejected widths
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 33, 0);
    cyc(0, 0, 0, 1);
    // Reconfigure mid-streaming at full capacity
    cyc(0, 1, 20, 0);
    idle(2);
    pixels(22);
    cyc(0, 1, 32, 1);
    idle(2);
    pixels(31);
    idle(1);
    pixels(3);
    // Reset while priming
    cyc(0, 1, 20, 0);
    idle(2);
    pixels(5);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    idle(1);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0,
          int'($urandom_range(0, 40)), $urandom_range(0, 3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/buffer_controlador.md
Name: buffer_controlador

Overview:
- Sequences a chain of N_UNIDADES buffer units (each a PROF_UNIDAD-deep FIFO with a free/active/inactive FSM) so they form one line buffer of the configured image width.
- On configuration it:
  - resets the units;
  - drives per-unit activation codes;
  - during priming, issues per-unit write/read requests so pixels ripple through the chain;
  - once a full line is stored, switches to steady-state streaming.
- Sits between the pixel source and the buffer unit array. The datapath (unit i q -> unit i+1 data) is external; this block generates control only.

Parameters:
N_UNIDADES, 4, number of buffer units in the chain
PROF_UNIDAD, 8, depth in words of each unit FIFO (power of two)
ANCHO_W, 6, width of the image-width configuration field

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
config_valida  in  1  one-cycle pulse: latch ancho_imagen and (re)configure
ancho_imagen  in  ANCHO_W  line width in pixels
pixel_valido  in  1  a new pixel is present at the chain input this cycle
reset_unidades  out  1  drives sclr of every unit
valor_activacion  out  2*N_UNIDADES  packed activation codes, unit i at bits [2i+1:2i]
write_req  out  N_UNIDADES  per-unit wrreq
read_req  out  N_UNIDADES  per-unit rdreq
config_lista  out  1  units configured, accepting pixels
linea_lista  out  1  full line stored, streaming
error_config  out  1  last configuration request rejected

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state = IDLE;
  - all outputs 0, except reset_unidades = 1 during the reset cycle;
  - pixel counter c = 0; latched width W = 0; active count k = 0.
- States: IDLE, RESET_UNID, CONFIG, PRIMING, STREAMING.
- config_valida, sampled in any state (including mid-PRIMING/STREAMING), is validated against the current ancho_imagen:
  - Invalid (ancho_imagen == 0 or ancho_imagen > N_UNIDADES*PROF_UNIDAD): error_config = 1 next cycle; go to IDLE; all request/activation outputs 0.
  - Valid: latch W, k = ceil(W/PROF_UNIDAD); clear error_config; go to RESET_UNID.
  - config_valida takes priority over pixel_valido in the same cycle.
- RESET_UNID (1 cycle):
  - reset_unidades = 1; valor_activacion = 0; requests 0; c = 0.
  - Next state is CONFIG.
- CONFIG (1 cycle):
  - valor_activacion unit i = 2'b01 for i < k, else 2'b10.
  - Next state is PRIMING.
  - Codes are registered and held unchanged through PRIMING and STREAMING. They return to 0 only in IDLE/RESET_UNID.
- PRIMING:
  - config_lista = 1.
  - On pixel_valido with counter c, let j = c / PROF_UNIDAD:
    - write_req[j] = 1;
    - write_req[i] = read_req[i] = 1 for i < j;
    - all others 0;
    - then c = c + 1.
  - When the accepted pixel makes c == W, the next state is STREAMING.
- STREAMING:
  - config_lista = 1, linea_lista = 1.
  - On pixel_valido: read_req[i] = write_req[i] = 1 for all i < k; inactive units 0.
  - c is frozen.
- Request timing: read_req/write_req are combinational from pixel_valido, the registered state and c, and are valid in the same cycle as pixel_valido. Every other output is registered.
- pixel_valido in IDLE, RESET_UNID or CONFIG is ignored: no requests, c unchanged.
- Last unit depth: when W is not a multiple of PROF_UNIDAD, the last active unit holds W-(k-1)*PROF_UNIDAD words. No unit is ever written while full or read while empty.
- reset mid-operation: returns to IDLE within one cycle with reset_unidades = 1; stored pixels are discarded.

Decomposition:
- Shared package buffer_pkg holds:
  - activation codes ACT_LIBRE = 2'b00, ACT_ACTIVA = 2'b01, ACT_NO_ACTIVA = 2'b10;
  - controller state encoding;
  - helper function for ceil-division by PROF_UNIDAD.
- One combinational sub-module, buffer_mapa_req: maps (state, c, k, pixel_valido) to write_req/read_req masks.

Test Plan:
- Reset, then config_valida with ancho_imagen=20 -> reset_unidades=1 at t+1; valor_activacion=8'b10_01_01_01 from t+2; config_lista=1 from t+3.
- W=20, 20 pixel_valido pulses:
  - pixels 0-7: write_req=0001, read_req=0000;
  - pixels 8-15: write_req=0011, read_req=0001;
  - pixels 16-19: write_req=0111, read_req=0011;
  - linea_lista=1 the cycle after pixel 19.
- Streaming at W=20, pixel 20 -> write_req=read_req=0111, unit 3 never requested; pixel_valido=0 -> all requests 0.
- config_valida with ancho_imagen=0, then ancho_imagen=33 -> error_config=1, IDLE, valor_activacion=0, pixel_valido yields no requests.
- Reconfiguration mid-STREAMING, ancho_imagen=32 -> RESET_UNID then CONFIG; valor_activacion=8'b01_01_01_01; linea_lista=1 only after 32 further pixels.
- reset asserted during PRIMING at c=5 -> next cycle all requests 0, config_lista=0, state IDLE.
